// File: rtl/day10_pkg.sv
// rtl/day10_pkg.sv - shared types and bit-count helpers for the day10 button solver
package day10_pkg;

  localparam int FN_W  = 16;
  localparam int FN_CW = $clog2(FN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } solver_state_e;

  function automatic logic [FN_CW-1:0] popcount(input logic [FN_W-1:0] v);
    logic [FN_CW-1:0] c;
    c = '0;
    for (int i = 0; i < FN_W; i++) c = c + {{(FN_CW-1){1'b0}}, v[i]};
    return c;
  endfunction

  // Returns FN_W for an all-zero argument; callers only pass nonzero values.
  function automatic logic [FN_CW-1:0] ctz(input logic [FN_W-1:0] v);
    logic [FN_CW-1:0] c;
    logic             hit;
    c   = FN_CW'(FN_W);
    hit = 1'b0;
    for (int i = 0; i < FN_W; i++) begin
      if (!hit && v[i]) begin
        c   = FN_CW'(i);
        hit = 1'b1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/day10_input_if.sv
// rtl/day10_input_if.sv - one machine description: target lights, button masks and counts
interface day10_input_if #(
  parameter int MAX_NUM_LIGHTS  = 10,
  parameter int MAX_NUM_BUTTONS = 13
);
  localparam int LIGHT_CNT_W = $clog2(MAX_NUM_LIGHTS + 1);
  localparam int BTN_CNT_W   = $clog2(MAX_NUM_BUTTONS + 1);

  logic [MAX_NUM_LIGHTS-1:0]                       target;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  buttons;
  logic [LIGHT_CNT_W-1:0]                          num_lights;
  logic [BTN_CNT_W-1:0]                            num_buttons;

  modport master (output target, buttons, num_lights, num_buttons);
  modport slave  (input  target, buttons, num_lights, num_buttons);
endinterface

// File: rtl/day10_gray_enumerator.sv
// rtl/day10_gray_enumerator.sv - walks subsets in Gray-code order, one flip per step
module day10_gray_enumerator
  import day10_pkg::*;
#(
  parameter  int MAX_NUM_BUTTONS = 13,
  localparam int BTN_CNT_W       = $clog2(MAX_NUM_BUTTONS + 1),
  localparam int F_W             = $clog2(MAX_NUM_BUTTONS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       step,
  input  logic [BTN_CNT_W-1:0]       num_buttons,
  output logic [F_W-1:0]             f,
  output logic [MAX_NUM_BUTTONS-1:0] mask,
  output logic                       last
);

  logic [MAX_NUM_BUTTONS-1:0] k;
  logic [FN_W-1:0]            k_next;
  logic [FN_W-1:0]            final_k;

  // f and last describe the step that the next 'step' pulse will perform.
  assign k_next  = FN_W'(k) + FN_W'(1);
  assign final_k = (FN_W'(1) << num_buttons) - FN_W'(1);
  assign f       = F_W'(ctz(k_next));
  assign last    = (k_next == final_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= '0;
      mask <= '0;
    end else if (start) begin
      k    <= '0;
      mask <= '0;
    end else if (step) begin
      k    <= k + 1'b1;
      mask <= mask ^ ({{(MAX_NUM_BUTTONS-1){1'b0}}, 1'b1} << f);
    end
  end

endmodule

// File: rtl/day10_button_solver.sv
// rtl/day10_button_solver.sv - minimum button presses per machine by exhaustive subset search
module day10_button_solver
  import day10_pkg::*;
#(
  parameter  int MAX_NUM_LIGHTS    = 10,
  parameter  int MAX_NUM_BUTTONS   = 13,
  parameter  int TOTAL_W           = 32,
  localparam int MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
  localparam int F_W               = $clog2(MAX_NUM_BUTTONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  day10_input_if.slave                 in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MAX_NUM_BUTTONS_W-1:0] out_presses,
  output logic                         out_solvable,
  input  logic                         clear_total,
  output logic [TOTAL_W-1:0]           total
);

  solver_state_e                                  state;
  logic [MAX_NUM_LIGHTS-1:0]                      target_q;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons_q;
  logic [MAX_NUM_BUTTONS_W-1:0]                   nb_q;
  logic [MAX_NUM_LIGHTS-1:0]                      acc;
  logic [FN_CW-1:0]                               best_cnt;
  logic                                           best_found;

  logic [MAX_NUM_LIGHTS-1:0]    light_mask;
  logic [MAX_NUM_BUTTONS_W-1:0] nb_clamped;
  logic                         accept;
  logic [F_W-1:0]               f;
  logic [MAX_NUM_BUTTONS-1:0]   gray_mask;
  logic                         last;
  logic [MAX_NUM_BUTTONS-1:0]   new_mask;
  logic [MAX_NUM_LIGHTS-1:0]    new_acc;
  logic [FN_CW-1:0]             new_pc;
  logic                         improves;

  always_comb begin
    light_mask = '0;
    for (int i = 0; i < MAX_NUM_LIGHTS; i++) light_mask[i] = (i < int'(in.num_lights));
    nb_clamped = (int'(in.num_buttons) > MAX_NUM_BUTTONS) ?
                 MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS) : in.num_buttons;
  end

  assign accept = (state == IDLE) && in_valid && in_ready;

  day10_gray_enumerator #(.MAX_NUM_BUTTONS(MAX_NUM_BUTTONS)) u_gray (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept),
    .step        (state == SEARCH),
    .num_buttons (nb_q),
    .f           (f),
    .mask        (gray_mask),
    .last        (last)
  );

  assign new_mask = gray_mask ^ ({{(MAX_NUM_BUTTONS-1){1'b0}}, 1'b1} << f);
  assign new_acc  = acc ^ buttons_q[f];
  assign new_pc   = popcount(FN_W'(new_mask));
  assign improves = (new_acc == target_q) && (!best_found || new_pc < best_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_presses  <= '0;
      out_solvable <= 1'b0;
      total        <= '0;
      target_q     <= '0;
      buttons_q    <= '0;
      nb_q         <= '0;
      acc          <= '0;
      best_cnt     <= '0;
      best_found   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target_q   <= in.target & light_mask;
            for (int b = 0; b < MAX_NUM_BUTTONS; b++) buttons_q[b] <= in.buttons[b] & light_mask;
            nb_q       <= nb_clamped;
            acc        <= '0;
            best_cnt   <= '0;
            best_found <= ((in.target & light_mask) == '0);
            in_ready   <= 1'b0;
            state      <= (nb_clamped == '0) ? DONE : SEARCH;
          end
        end
        SEARCH: begin
          acc <= new_acc;
          if (improves) begin
            best_found <= 1'b1;
            best_cnt   <= new_pc;
          end
          if (last) state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; the handshake starts on the next.
          if (!out_valid) begin
            out_valid    <= 1'b1;
            out_presses  <= best_found ? MAX_NUM_BUTTONS_W'(best_cnt) : '0;
            out_solvable <= best_found;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (clear_total)
        total <= '0;
      else if (state == DONE && out_valid && out_ready && out_solvable)
        total <= total + TOTAL_W'(out_presses);
    end
  end

endmodule

// File: doc/day10_button_solver.md
# day10_button_solver

Sequences a brute-force search over button subsets for one machine description, an instance of `day10_input_if`, and finds the minimum number of presses that turns all-off lights into the target arrangement. Each press toggles the button's light mask, so the search covers every subset. It sits between the input parser and the top-level result. Machines arrive one at a time over a valid/ready handshake. Per-machine results leave over a second valid/ready handshake, and a running total of the minima is kept internally.

## Interface
- `MAX_NUM_LIGHTS`, default 10: light mask width.
- `MAX_NUM_BUTTONS`, default 13: button slots.
- `TOTAL_W`, default 32: running-total width.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: machine on `in` is valid.
- `in_ready`, output, 1: solver idle and can accept.
- `in`, input, `day10_input_if` (interface port): machine description, sampled only on accept.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes result.
- `out_presses`, output, `MAX_NUM_BUTTONS_W`: minimum presses; 0 when unsolvable.
- `out_solvable`, output, 1: at least one subset matched.
- `clear_total`, input, 1: synchronous clear of `total`.
- `total`, output, `TOTAL_W`: sum of `out_presses` over accepted solvable results.

## Operation
- FSM states are IDLE, SEARCH and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - latch `buttons`, `num_buttons` and `num_lights`;
    - latch `target` masked to bits `< num_lights`;
    - mask every latched button to bits `< num_lights`;
    - set `acc`=0, subset mask=0, Gray index k=0;
    - set `best` = target==0 ? 0 : none.
  - Next state is SEARCH, or DONE if `num_buttons`==0.
- **SEARCH**, one subset per cycle, Gray-code order:
  - k←k+1; flip index f = count of trailing zeros of k.
  - Toggle subset bit f; `acc` ^= `buttons[f]`.
  - If the new `acc`==target and popcount(new mask) < `best`, update `best`.
  - After processing k = 2^num_buttons − 1, go to DONE.
  - Button slots `≥ num_buttons` are never flipped.
- **DONE**
  - `out_valid`=1; `out_presses`/`out_solvable` are driven from `best`.
  - On `out_ready`: if solvable, `total` += `out_presses`, wrapping mod 2^`TOTAL_W`. Then go to IDLE.
- `clear_total` sets `total` to 0 on the next edge and wins over a simultaneous accumulate.
- `in` bits at or above `num_lights`/`num_buttons` are don't-care.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_presses`=0, `out_solvable`=0, `total`=0, all internal registers 0.
- Latency: `out_valid` first rises 2^`num_buttons` cycles after the accepting edge. For `num_buttons`=0 this is 1 cycle; for 13 it is 8192 cycles.
- `in_ready` is low in SEARCH and DONE. No new machine is accepted in the same cycle a result is consumed; IDLE lasts at least 1 cycle.
- `out_presses`/`out_solvable` are registered and stay stable while `out_valid && !out_ready`.
- Reset asserted mid-SEARCH or in DONE abandons the machine and clears `total`.
- Popcount and comparison are within one cycle: a combinational popcount over `MAX_NUM_BUTTONS` bits.

## Structure
- `day10_pkg` holds:
  - `solver_state_e` (IDLE/SEARCH/DONE);
  - functions `ctz(k)` and `popcount(mask)`, parameterised by width through a localparam-sized argument or a generic loop.
- Sub-module `day10_gray_enumerator`:
  - inputs `start`, `step`, `num_buttons`;
  - outputs flip index `f`, current subset mask, and `last` (asserted on k = 2^n − 1).
- The solver instantiates it and owns the FSM, `acc`, `best` and `total`.

## Test plan
- **Machine A**
  - Stimulus: `num_lights`=4, target=4'b0110, `num_buttons`=6, buttons = {4'b1000, 4'b1010, 4'b0100, 4'b1100, 4'b0101, 4'b0011} (bit0 = light 0).
  - Required: `out_presses`=2, solvable, `out_valid` exactly 64 cycles after accept.
- **Back-to-back A, B, C**
  - B: `num_lights`=5, target=5'b01000, buttons {5'b11101, 5'b01100, 5'b10001, 5'b00111, 5'b11110}; expect 3.
  - C: `num_lights`=6, target=6'b101110, buttons {6'b011111, 6'b011001, 6'b110111, 6'b000110}; expect 2.
  - `out_ready` is tied 1; required: `total`=7 after the third result.
- **Target 0**
  - Stimulus: any buttons.
  - Required: `out_presses`=0, solvable, `total` unchanged by +0.
- **Unsolvable, then edge cases**
  - Unsolvable: `num_lights`=2, one button 2'b01, target 2'b10. Required: `out_solvable`=0, `out_presses`=0, `total` unchanged.
  - Zero buttons: `num_buttons`=0 and target≠0. Required: unsolvable after 1 cycle.
  - Garbage upper bits: garbage above `num_lights` in target/buttons does not change the results above.
- **Backpressure**
  - Stimulus: hold `out_ready`=0 for 10 cycles in DONE.
  - Required: outputs stable, `in_ready`=0, `total` unchanged; `clear_total` pulsed together with `out_ready` leaves `total`=0.
- **Reset mid-operation**
  - Stimulus: assert `rst_n`=0 during SEARCH of Machine A.
  - Required: outputs return to reset values immediately; a subsequent Machine A yields 2 and `total`=2.
